seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a common-anode bank of DIGITS seven-segment displays. It generalises the single-digit hex decoder to a parametrised scanning block with:
- a shadow register that captures display data on a load strobe,
- a refresh prescaler with a one-cycle anode dead time to suppress ghosting,
- "Err " / "good" status overlays.

It sits between the FP assembly status logic and the board display pins.

---
 rtl/seg7_scan_driver.sv | 214 +++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with load-strobed shadow data,
// dead-time anode blanking and "Err "/"good" overlays. Optional: SEG7_LZ_SUPPRESS_EN.
module seg7_scan_driver #(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  err,
    input  logic                  good,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an
);

    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_R     = 7'b1111010;
    localparam logic [6:0] SEG_G     = 7'b0000100;
    localparam logic [6:0] SEG_O     = 7'b1100010;
    localparam logic [6:0] SEG_D     = 7'b1000010;

    typedef enum logic [1:0] {
        MODE_HEX,
        MODE_GOOD,
        MODE_ERR
    } mode_e;

    // Shadow register
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   dp_q;
    logic                err_q;
    logic                good_q;

    // Scan state
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // Registered outputs
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_n_q, dp_n_d;

    logic                tick;
    mode_e               mode;
    logic [3:0]          nib_sel;
    logic                dp_sel;
    logic                lz_blank;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Overlay text occupies digits 3..0; any wider bank is blank above it.
    function automatic logic [6:0] overlay_seg(input mode_e m, input int digit);
        logic [6:0] s;
        s = SEG_BLANK;
        if (m == MODE_ERR) begin
            case (digit)
                3:       s = SEG_E;
                2, 1:    s = SEG_R;
                default: s = SEG_BLANK;
            endcase
        end else if (m == MODE_GOOD) begin
            case (digit)
                3:       s = SEG_G;
                2, 1:    s = SEG_O;
                0:       s = SEG_D;
                default: s = SEG_BLANK;
            endcase
        end
        return s;
    endfunction

    // NOTE: every always_ff uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            dp_q    <= '0;
            err_q   <= 1'b0;
            good_q  <= 1'b0;
        end else if (load) begin
            value_q <= value;
            dp_q    <= dp;
            err_q   <= err;
            good_q  <= good;
        end
    end

    assign tick  = &cnt_q;
    assign cnt_d = cnt_q + 1'b1;

    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        if (err_q) begin
            mode = MODE_ERR;
        end else if (good_q) begin
            mode = MODE_GOOD;
        end else begin
            mode = MODE_HEX;
        end
    end

    // NOTE: defaults are assigned before the loop so no path leaves a
    // combinational output unassigned, which would infer a latch.
    always_comb begin
        nib_sel = '0;
        dp_sel  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_sel = value_q[4*k +: 4];
                dp_sel  = dp_q[k];
            end
        end
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    // Blank digits above the most-significant nonzero nibble; an all-zero
    // shadow blanks the whole bank, so a freshly reset display stays dark.
    logic [IDX_W-1:0] msd;
    logic             any_nz;

    always_comb begin
        msd    = '0;
        any_nz = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (value_q[4*k +: 4] != 4'h0) begin
                msd    = IDX_W'(k);
                any_nz = 1'b1;
            end
        end
        lz_blank = !any_nz || (idx_q > msd);
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        an_d   = '1;
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        if (!tick) begin
            an_d = ~(DIGITS'(1) << idx_q);
            if (mode == MODE_HEX) begin
                seg_d  = lz_blank ? SEG_BLANK : hex_seg(nib_sel);
                dp_n_d = ~dp_sel;
            end else begin
                seg_d  = overlay_seg(mode, int'(idx_q));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dp_n_q <= 1'b1;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp_n = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 4-digit and a 6-digit instance with
// DIV_W=2, sharing clock, reset, overlay and load strobes.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        err, good, load;
    logic [6:0]  seg4;
    logic        dp_n4;
    logic [3:0]  an4;

    logic [23:0] value6;
    logic [5:0]  dp6;
    logic [6:0]  seg6;
    logic        dp_n6;
    logic [5:0]  an6;

    int test_cnt = 0;
    int fail_cnt = 0;

    localparam logic [6:0] BLANK = 7'b1111111;
`ifdef SEG7_LZ_SUPPRESS_EN
    localparam logic [6:0] SEG_CLR = 7'b1111111;
`else
    localparam logic [6:0] SEG_CLR = 7'b0000001;
`endif

    // Expected an/seg for edges 1..17 after reset release, value 3A0F loaded on edge 1.
    logic [3:0] an_tbl [17] = '{4'b1110, 4'b1110, 4'b1110, 4'b1111,
                                4'b1101, 4'b1101, 4'b1101, 4'b1111,
                                4'b1011, 4'b1011, 4'b1011, 4'b1111,
                                4'b0111, 4'b0111, 4'b0111, 4'b1111,
                                4'b1110};
    logic [6:0] seg_tbl [17] = '{SEG_CLR, 7'b0111000, 7'b0111000, BLANK,
                                 7'b0000001, 7'b0000001, 7'b0000001, BLANK,
                                 7'b0001000, 7'b0001000, 7'b0001000, BLANK,
                                 7'b0000110, 7'b0000110, 7'b0000110, BLANK,
                                 7'b0111000};
    // Indexed by digit number (0 = rightmost).
    logic [6:0] err_exp  [4] = '{7'b1111111, 7'b1111010, 7'b1111010, 7'b0110000};
    logic [6:0] good_exp [4] = '{7'b1000010, 7'b1100010, 7'b1100010, 7'b0000100};
`ifdef SEG7_LZ_SUPPRESS_EN
    logic [6:0] lz_exp   [4] = '{7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111};
`else
    logic [6:0] lz_exp   [4] = '{7'b0000001, 7'b0100100, 7'b0000001, 7'b0000001};
`endif
    logic       lz_dpn   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .DIV_W(2)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .dp    (dp),
        .err   (err),
        .good  (good),
        .load  (load),
        .seg   (seg4),
        .dp_n  (dp_n4),
        .an    (an4)
    );

    seg7_scan_driver #(.DIGITS(6), .DIV_W(2)) u_dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value6),
        .dp    (dp6),
        .err   (err),
        .good  (good),
        .load  (load),
        .seg   (seg6),
        .dp_n  (dp_n6),
        .an    (an6)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic e, input logic g);
        value = v;
        dp    = d;
        err   = e;
        good  = g;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_dig4(input int k, output logic [6:0] s, output logic d);
        logic [3:0] want;
        bit         found;
        want  = ~(4'b0001 << k);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            if (an4 === want) found = 1'b1;
        end
        if (!found) begin
            test_cnt++;
            fail_cnt++;
            $error("FAIL wait_dig4[%0d]: an observed %0b, digit never lit in 40 cycles", k, an4);
        end
        s = seg4;
        d = dp_n4;
    endtask

    task automatic wait_dig6(input int k, output logic [6:0] s);
        logic [5:0] want;
        bit         found;
        want  = ~(6'b000001 << k);
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            step();
            if (an6 === want) found = 1'b1;
        end
        if (!found) begin
            test_cnt++;
            fail_cnt++;
            $error("FAIL wait_dig6[%0d]: an observed %0b, digit never lit in 60 cycles", k, an6);
        end
        s = seg6;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] s;
        logic       d;

        rst_n  = 1'b0;
        value  = '0;
        dp     = '0;
        err    = 1'b0;
        good   = 1'b0;
        load   = 1'b0;
        value6 = '0;
        dp6    = '0;

        // Reset held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_an4", 32'(an4), 32'(4'b1111));
            check("rst_seg4", 32'(seg4), 32'(BLANK));
        end
        check("rst_dpn4", 32'(dp_n4), 32'(1'b1));
        check("rst_an6", 32'(an6), 32'(6'b111111));

        // Release with a load of 3A0F on the first edge; walk the full scan
        rst_n = 1'b1;
        value = 16'h3A0F;
        load  = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            step();
            if (e == 1) load = 1'b0;
            if (e <= 17) begin
                check($sformatf("scan_an4_e%0d", e), 32'(an4), 32'(an_tbl[e-1]));
                check($sformatf("scan_seg4_e%0d", e), 32'(seg4), 32'(seg_tbl[e-1]));
            end
            if (e == 21) check("scan_an6_dig5", 32'(an6), 32'(6'b011111));
            if (e == 24) check("scan_an6_dead", 32'(an6), 32'(6'b111111));
            if (e == 25) check("scan_an6_wrap", 32'(an6), 32'(6'b111110));
        end
        check("scan_dpn4", 32'(dp_n4), 32'(1'b1));

        // err has priority over good; dp requests suppressed under overlay
        do_load(16'h3A0F, 4'b1111, 1'b1, 1'b1);
        for (int k = 3; k >= 0; k--) begin
            wait_dig4(k, s, d);
            check($sformatf("err_seg_d%0d", k), 32'(s), 32'(err_exp[k]));
            check($sformatf("err_dpn_d%0d", k), 32'(d), 32'(1'b1));
        end
        wait_dig6(5, s);
        check("err6_seg_d5", 32'(s), 32'(BLANK));
        wait_dig6(4, s);
        check("err6_seg_d4", 32'(s), 32'(BLANK));
        wait_dig6(3, s);
        check("err6_seg_d3", 32'(s), 32'(7'b0110000));

        do_load(16'h3A0F, 4'b1111, 1'b0, 1'b1);
        for (int k = 3; k >= 0; k--) begin
            wait_dig4(k, s, d);
            check($sformatf("good_seg_d%0d", k), 32'(s), 32'(good_exp[k]));
            check($sformatf("good_dpn_d%0d", k), 32'(d), 32'(1'b1));
        end

        // Load coinciding with the tick that moves idx 3 -> 0
        do_load(16'hFFFF, 4'b0000, 1'b0, 1'b0);
        wait_dig4(2, s, d);
        wait_dig4(3, s, d);
        check("coll_pre_seg", 32'(s), 32'(7'b0111000));
        step();
        step();
        value = 16'h0001;
        load  = 1'b1;
        step();
        load  = 1'b0;
        check("coll_dead_an", 32'(an4), 32'(4'b1111));
        check("coll_dead_seg", 32'(seg4), 32'(BLANK));
        step();
        check("coll_lit_an", 32'(an4), 32'(4'b1110));
        check("coll_lit_seg", 32'(seg4), 32'(7'b1001111));

        // Leading-zero case: value 0050, dp on digit 3
        do_load(16'h0050, 4'b1000, 1'b0, 1'b0);
        for (int k = 3; k >= 0; k--) begin
            wait_dig4(k, s, d);
            check($sformatf("lz_seg_d%0d", k), 32'(s), 32'(lz_exp[k]));
            check($sformatf("lz_dpn_d%0d", k), 32'(d), 32'(lz_dpn[k]));
        end

        // Asynchronous reset mid-scan, no clock edge needed
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_an4", 32'(an4), 32'(4'b1111));
        check("async_seg4", 32'(seg4), 32'(BLANK));
        check("async_dpn4", 32'(dp_n4), 32'(1'b1));
        check("async_an6", 32'(an6), 32'(6'b111111));
        step();
        rst_n = 1'b1;
        step();
        check("rel_an4", 32'(an4), 32'(4'b1110));
        check("rel_seg4", 32'(seg4), 32'(SEG_CLR));
        wait_dig4(1, s, d);
        check("rel_seg_d1", 32'(s), 32'(SEG_CLR));
        wait_dig4(3, s, d);
        check("rel_dpn_d3", 32'(d), 32'(1'b1));

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
